load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on a single-ported data memory.
// Latency: loads and SW respond 2 cycles after accept, SB/SH (read-modify-write) 3 cycles, rejected requests 1 cycle.
// Backpressure: req_ready is high only in IDLE; one request is in flight at a time and the response pulse cannot be stalled.
//
// Ports:
//   clock, reset                    single clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_write, funct3, byte_addr,   request fields (store vs load, RISC-V width/sign code,
//   store_data                      byte address, store operand)
//   resp_valid, load_data,          one-cycle completion pulse, extended load result,
//   access_err                      rejection flag (meaningful only with resp_valid)
//   memRead, memWrite, address,     data-memory port; readData is combinational,
//   writeData, readData             memory writes on the rising edge
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word
// accesses with access_err; when undefined, misaligned offsets are truncated.

module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  // CPU request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH+1:0] byte_addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  // CPU response
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  access_err,
  // Data memory
  output logic                  memRead,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic [DATA_WIDTH-1:0] readData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsuState_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  lsuState_t             stateReg;
  lsuState_t             stateNext;

  // Request fields captured on acceptance; the memory port is driven only from these.
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [1:0]            offsetReg;
  logic [2:0]            funct3Reg;
  logic                  writeReg;
  logic                  errReg;
  // Holds store_data from accept; for SB/SH it is overwritten with the merged word at the end of READ.
  logic [DATA_WIDTH-1:0] writeDataReg;
  logic [DATA_WIDTH-1:0] loadDataReg;

  logic                  accept;
  logic                  codeBad;
  logic                  misaligned;
  logic                  reqErr;

  // Select the addressed byte/halfword of a memory word and extend it to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] extractLoad(
    input logic [DATA_WIDTH-1:0] word,
    input logic [2:0]            code,
    input logic [1:0]            off
  );
    logic [7:0]            laneB;
    logic [15:0]           laneH;
    logic [DATA_WIDTH-1:0] res;
    laneB = word[{off, 3'b000} +: 8];
    // Halfword lane uses only off[1]; a set off[0] is truncated when alignment is not enforced.
    laneH = word[{off[1], 4'b0000} +: 16];
    case (code)
      F3_B:    res = {{(DATA_WIDTH-8){laneB[7]}}, laneB};
      F3_H:    res = {{(DATA_WIDTH-16){laneH[15]}}, laneH};
      F3_BU:   res = {{(DATA_WIDTH-8){1'b0}}, laneB};
      F3_HU:   res = {{(DATA_WIDTH-16){1'b0}}, laneH};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed byte/halfword lanes of the word read from memory.
  function automatic logic [DATA_WIDTH-1:0] mergeStore(
    input logic [DATA_WIDTH-1:0] word,
    input logic [DATA_WIDTH-1:0] data,
    input logic [2:0]            code,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] res;
    res = word;
    if (code == F3_B) begin
      res[{off, 3'b000} +: 8] = data[7:0];
    end else begin
      res[{off[1], 4'b0000} +: 16] = data[15:0];
    end
    return res;
  endfunction

  // Request classification, evaluated on the live request so a rejection costs no memory cycle.
  always_comb begin
    codeBad    = 1'b0;
    misaligned = 1'b0;
    if (req_write) begin
      codeBad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    end else begin
      codeBad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                  funct3 == F3_BU || funct3 == F3_HU);
    end
`ifdef LSU_MISALIGN_CHECK_EN
    // funct3[1:0]==01 covers LH/LHU/SH; 010 covers LW/SW.
    if (funct3[1:0] == 2'b01 && byte_addr[0]) begin
      misaligned = 1'b1;
    end
    if (funct3 == F3_W && byte_addr[1:0] != 2'b00) begin
      misaligned = 1'b1;
    end
`endif
    reqErr = codeBad || misaligned;
  end

  assign accept = req_valid && req_ready;

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          if (reqErr) begin
            stateNext = RESP;
          end else if (req_write && funct3 == F3_W) begin
            stateNext = WRITE;
          end else begin
            stateNext = READ;
          end
        end
      end
      READ:    stateNext = writeReg ? WRITE : RESP;
      WRITE:   stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg     <= IDLE;
      addrReg      <= '0;
      offsetReg    <= '0;
      funct3Reg    <= '0;
      writeReg     <= 1'b0;
      errReg       <= 1'b0;
      writeDataReg <= '0;
      loadDataReg  <= '0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        addrReg      <= byte_addr[ADDR_WIDTH+1:2];
        offsetReg    <= byte_addr[1:0];
        funct3Reg    <= funct3;
        writeReg     <= req_write;
        errReg       <= reqErr;
        writeDataReg <= store_data;
      end
      if (stateReg == READ && writeReg) begin
        writeDataReg <= mergeStore(readData, writeDataReg, funct3Reg, offsetReg);
      end
      // load_data changes only when a response is about to be presented:
      // the extracted value for loads, zero for stores and rejections.
      if (stateNext == RESP) begin
        if (stateReg == READ && !writeReg) begin
          loadDataReg <= extractLoad(readData, funct3Reg, offsetReg);
        end else begin
          loadDataReg <= '0;
        end
      end
    end
  end

  // Outputs are gated by reset so they read as zero during the reset cycle itself,
  // before the synchronous reset has taken effect on the registers. The memWrite
  // gate in particular suppresses the write at the edge where reset is sampled.
  assign req_ready  = (stateReg == IDLE)  && !reset;
  assign memRead    = (stateReg == READ)  && !reset;
  assign memWrite   = (stateReg == WRITE) && !reset;
  assign resp_valid = (stateReg == RESP)  && !reset;
  assign access_err = (stateReg == RESP)  && errReg && !reset;
  assign address    = reset ? '0 : addrReg;
  assign writeData  = reset ? '0 : writeDataReg;
  assign load_data  = reset ? '0 : loadDataReg;

endmodule
